// File: rtl/pagamento_parametrizado.sv
// pagamento_parametrizado: parametrised coffee-machine payment controller.
// Accumulates credit against a latched product price and returns change or refunds as unit pulses.
module pagamento_parametrizado #(
    parameter int CREDIT_W       = 5,
    parameter int PRECO0         = 2,
    parameter int PRECO1         = 4,
    parameter int PRECO2         = 5,
    parameter int PRECO3         = 8,
    parameter int VALOR1         = 2,
    parameter int VALOR2         = 5,
    parameter int VALOR3         = 10,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                INICIAR,
    input  logic [1:0]          PRODUTO,
    input  logic                CEDULA_VALIDA,
    input  logic [1:0]          CEDULA,
    input  logic                CANCELAR,
    output logic [1:0]          SAIDA,
    output logic [CREDIT_W-1:0] CREDITO,
    output logic                LIBERAR,
    output logic                TROCO_PULSO,
    output logic                REJEITADA,
    output logic                OCUPADO
);
    localparam int SOMA_W  = CREDIT_W + 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CICLOS);
    localparam logic [TIMER_W-1:0] TIMER_FIM = TIMER_W'(TIMEOUT_CICLOS - 1);

    typedef enum logic [1:0] {AGUARDANDO, RECEBENDO, PAGO, DEVOLVENDO} estado_t;

    estado_t             estado, estado_d;
    logic [CREDIT_W-1:0] credito, credito_d;
    logic [CREDIT_W-1:0] preco, preco_d;
    logic [TIMER_W-1:0]  timer, timer_d;
    logic                resultado, resultado_d;   // 1 = paid, 0 = refunded
    logic                rejeitada, rejeitada_d;
    logic                recusa, recusa_d;         // zero-credit refund shown for one idle cycle
    logic [SOMA_W-1:0]   valor, soma;
    logic                aceita;

    function automatic logic [CREDIT_W-1:0] preco_de(input logic [1:0] p);
        case (p)
            2'b00:   return CREDIT_W'(PRECO0);
            2'b01:   return CREDIT_W'(PRECO1);
            2'b10:   return CREDIT_W'(PRECO2);
            default: return CREDIT_W'(PRECO3);
        endcase
    endfunction

    always_comb begin
        case (CEDULA)
            2'b01:   valor = SOMA_W'(VALOR1);
            2'b10:   valor = SOMA_W'(VALOR2);
            2'b11:   valor = SOMA_W'(VALOR3);
            default: valor = '0;
        endcase
    end

    // One extra bit catches overflow instead of letting the credit wrap.
    assign soma   = {1'b0, credito} + valor;
    assign aceita = CEDULA_VALIDA && (CEDULA != 2'b00) && !soma[CREDIT_W];

    always_comb begin
        // NOTE: every signal gets a default first so no branch can infer a latch.
        estado_d    = estado;
        credito_d   = credito;
        preco_d     = preco;
        timer_d     = timer;
        resultado_d = resultado;
        rejeitada_d = 1'b0;
        recusa_d    = 1'b0;

        case (estado)
            AGUARDANDO: begin
                rejeitada_d = CEDULA_VALIDA;
                if (INICIAR) begin
                    preco_d   = preco_de(PRODUTO);
                    credito_d = '0;
                    timer_d   = '0;
                    estado_d  = RECEBENDO;
                end
            end
            RECEBENDO: begin
                if (credito >= preco) begin
                    rejeitada_d = CEDULA_VALIDA;
                    estado_d    = PAGO;
                end else if (CANCELAR || (!aceita && timer == TIMER_FIM)) begin
                    rejeitada_d = CEDULA_VALIDA;
                    resultado_d = 1'b0;
                    if (credito == '0) begin
                        estado_d = AGUARDANDO;
                        recusa_d = 1'b1;
                    end else begin
                        estado_d = DEVOLVENDO;
                    end
                end else if (aceita) begin
                    credito_d = soma[CREDIT_W-1:0];
                    timer_d   = '0;
                end else begin
                    rejeitada_d = CEDULA_VALIDA;
                    timer_d     = timer + 1'b1;
                end
            end
            PAGO: begin
                rejeitada_d = CEDULA_VALIDA;
                resultado_d = 1'b1;
                credito_d   = credito - preco;
                estado_d    = (credito == preco) ? AGUARDANDO : DEVOLVENDO;
            end
            default: begin
                rejeitada_d = CEDULA_VALIDA;
                if (credito <= CREDIT_W'(1)) begin
                    credito_d = '0;
                    estado_d  = AGUARDANDO;
                end else begin
                    credito_d = credito - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking so every register updates from pre-edge values.
        if (RESET) begin
            estado    <= AGUARDANDO;
            credito   <= '0;
            preco     <= '0;
            timer     <= '0;
            resultado <= 1'b0;
            rejeitada <= 1'b0;
            recusa    <= 1'b0;
        end else begin
            estado    <= estado_d;
            credito   <= credito_d;
            preco     <= preco_d;
            timer     <= timer_d;
            resultado <= resultado_d;
            rejeitada <= rejeitada_d;
            recusa    <= recusa_d;
        end
    end

    always_comb begin
        case (estado)
            AGUARDANDO: SAIDA = recusa ? 2'b10 : 2'b00;
            RECEBENDO:  SAIDA = 2'b01;
            PAGO:       SAIDA = 2'b11;
            default:    SAIDA = resultado ? 2'b11 : 2'b10;
        endcase
    end

    assign CREDITO     = credito;
    assign LIBERAR     = (estado == PAGO);
    assign TROCO_PULSO = (estado == DEVOLVENDO) && (credito != '0);
    assign REJEITADA   = rejeitada;
    assign OCUPADO     = (estado != AGUARDANDO);
endmodule
